// File: rtl/uart_tx_frame_serializer.sv
// rtl/uart_tx_frame_serializer.sv - UART transmit framer: start, payload, optional parity, 1 or 2 stop bits.
// Accepts a new frame while idle or on the final stop bit, so back-to-back frames have no idle gap.
module uart_tx_frame_serializer #(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH + 4) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  input  logic                  msb_first,
  output logic                  tx_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  bit_count,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_DATA = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] p_ordered;
  logic                  par_en_r;
  logic                  par_bit_r;
  logic                  stop2_r;
  logic                  accept;

  // Bit order is resolved at latch time so the shifter always sends bit 0 first.
  always_comb begin
    p_ordered = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      p_ordered[i] = msb_first ? p_data[DATA_WIDTH-1-i] : p_data[i];
    end
  end

  // done is high exactly on the final stop bit, which is the only in-frame acceptance point.
  assign accept = data_valid && ((state == IDLE) || ((state == STOP) && done));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      stop2_r   <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_count <= '0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if ((state == STOP) && !done) begin
            done      <= 1'b1;
            bit_count <= bit_count + ONE;
          end else if (accept) begin
            state     <= START;
            shreg     <= p_ordered;
            par_en_r  <= par_en;
            par_bit_r <= (^p_data) ^ par_typ;
            stop2_r   <= stop2;
            tx_out    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            bit_count <= '0;
          end else begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_count <= '0;
          end
        end
        START: begin
          state     <= DATA;
          tx_out    <= shreg[0];
          shreg     <= shreg >> 1;
          bit_count <= bit_count + ONE;
        end
        DATA: begin
          bit_count <= bit_count + ONE;
          if (bit_count == LAST_DATA) begin
            if (par_en_r) begin
              state  <= PARITY;
              tx_out <= par_bit_r;
            end else begin
              state  <= STOP;
              tx_out <= 1'b1;
              done   <= !stop2_r;
            end
          end else begin
            tx_out <= shreg[0];
            shreg  <= shreg >> 1;
          end
        end
        PARITY: begin
          state     <= STOP;
          tx_out    <= 1'b1;
          done      <= !stop2_r;
          bit_count <= bit_count + ONE;
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb/tb_uart_tx_frame_serializer.sv - self-checking bench with a queue-based frame model.
module tb_uart_tx_frame_serializer;

  localparam int DW  = 8;
  localparam int CW  = $clog2(DW + 4) + 1;
  localparam int DW5 = 5;
  localparam int CW5 = $clog2(DW5 + 4) + 1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] p_data;
  logic          data_valid, par_en, par_typ, stop2, msb_first;
  logic          tx_out, busy, done;
  logic [CW-1:0] bit_count;

  logic [DW5-1:0] p_data5;
  logic           data_valid5;
  logic           tx5, busy5, done5;
  logic [CW5-1:0] bc5;

  int checks = 0;
  int fails  = 0;

  uart_tx_frame_serializer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst_n), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .msb_first(msb_first),
    .tx_out(tx_out), .busy(busy), .bit_count(bit_count), .done(done)
  );

  uart_tx_frame_serializer #(.DATA_WIDTH(DW5)) dut5 (
    .clk(clk), .rst(rst_n), .p_data(p_data5), .data_valid(data_valid5),
    .par_en(1'b1), .par_typ(1'b0), .stop2(1'b0), .msb_first(1'b0),
    .tx_out(tx5), .busy(busy5), .bit_count(bc5), .done(done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: each frame becomes a list of per-cycle line states.
  typedef struct packed {
    logic          tx;
    logic          busy;
    logic          done;
    logic [CW-1:0] bc;
  } exp_t;

  localparam exp_t IDLE_E = '{tx: 1'b1, busy: 1'b0, done: 1'b0, bc: '0};

  exp_t q[$];
  exp_t cur = IDLE_E;
  logic allowed;

  function automatic void build(input logic [DW-1:0] d, input logic pe, input logic pt,
                                input logic s2, input logic msb);
    int n;
    int len;
    exp_t e;
    len = 1 + DW + int'(pe) + 1 + int'(s2);
    n = 0;
    e = '{tx: 1'b0, busy: 1'b1, done: 1'b0, bc: CW'(n)};
    q.push_back(e); n++;
    for (int k = 0; k < DW; k++) begin
      e.tx = msb ? d[DW-1-k] : d[k];
      e.bc = CW'(n);
      q.push_back(e); n++;
    end
    if (pe) begin
      e.tx = (($countones(d) % 2) == 1) ^ pt;
      e.bc = CW'(n);
      q.push_back(e); n++;
    end
    while (n < len) begin
      e.tx   = 1'b1;
      e.bc   = CW'(n);
      e.done = (n == len - 1);
      q.push_back(e); n++;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur = IDLE_E;
    end else begin
      allowed = !cur.busy || cur.done;
      if (allowed && data_valid) build(p_data, par_en, par_typ, stop2, msb_first);
      if (q.size() > 0) cur = q.pop_front();
      else cur = IDLE_E;
    end
  end

  always @(negedge clk) begin
    check("cycle", {tx_out, busy, done, bit_count}, cur);
  end

  task automatic send_expect(input string name, input logic [DW-1:0] d, input logic pe,
                             input logic pt, input logic s2, input logic msb,
                             input logic [31:0] bits, input int n);
    @(negedge clk); #1;
    p_data = d; par_en = pe; par_typ = pt; stop2 = s2; msb_first = msb; data_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, " tx"}, tx_out, bits[n-1-i]);
      check({name, " state"}, {busy, done, bit_count}, {1'b1, (i == n - 1), CW'(i)});
      if (i == 0) begin
        #1;
        data_valid = 1'b0;
        p_data = DW'($urandom);
        par_en = ~pe; par_typ = ~pt; stop2 = ~s2; msb_first = ~msb;
      end
    end
    @(negedge clk);
    check({name, " idle"}, {tx_out, busy, done, bit_count}, {1'b1, 1'b0, 1'b0, CW'(0)});
  endtask

  initial begin
    rst_n = 1'b1; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;
    stop2 = 1'b0; msb_first = 1'b0; data_valid5 = 1'b0; p_data5 = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", {tx_out, busy, done, bit_count}, {1'b1, 1'b0, 1'b0, CW'(0)});
    #1 rst_n = 1'b1;

    send_expect("a5_plain",  8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 32'b0101001011, 10);
    send_expect("a5_even",   8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 32'b01010010101, 11);
    send_expect("a5_odd",    8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 32'b01010010111, 11);
    send_expect("81_msb_s2", 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 32'b01000000111, 11);

    // Five-bit instance: 0x13, even parity.
    @(negedge clk); #1;
    p_data5 = 5'h13; data_valid5 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("dw5 tx", tx5, (8'b01100111 >> (7 - i)) & 1);
      check("dw5 state", {busy5, done5, bc5}, {1'b1, (i == 7), CW5'(i)});
      if (i == 0) begin #1; data_valid5 = 1'b0; p_data5 = 5'h0C; end
    end
    @(negedge clk);
    check("dw5 idle", {tx5, busy5}, 2'b10);

    // Back-to-back with data_valid held high across a whole frame.
    @(negedge clk); #1;
    p_data = 8'h55; par_en = 1'b0; stop2 = 1'b0; msb_first = 1'b0; data_valid = 1'b1;
    @(negedge clk);
    check("b2b start", {tx_out, busy, bit_count}, {1'b0, 1'b1, CW'(0)});
    #1 p_data = 8'h0F;
    @(negedge clk);
    @(negedge clk);
    check("b2b latched bit1", tx_out, 1'b0);
    repeat (8) @(negedge clk);
    check("b2b 2nd start", {tx_out, busy, done, bit_count}, {1'b0, 1'b1, 1'b0, CW'(0)});
    #1 data_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset during a data bit.
    @(negedge clk); #1;
    p_data = 8'h3C; data_valid = 1'b1;
    @(negedge clk); #1 data_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("async reset", {tx_out, busy, done, bit_count}, {1'b1, 1'b0, 1'b0, CW'(0)});
    @(negedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("post reset idle", {tx_out, busy}, 2'b10);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (!rst_n) rst_n = 1'b1;
      data_valid = ($urandom_range(0, 3) == 0);
      p_data = DW'($urandom);
      par_en = $urandom_range(0, 1); par_typ = $urandom_range(0, 1);
      stop2 = $urandom_range(0, 1);  msb_first = $urandom_range(0, 1);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1 check("rand reset", {tx_out, busy, done}, 3'b100);
      end
    end
    @(negedge clk); #1 data_valid = 1'b0; rst_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
